// File: rtl/cheat_table_if.sv
// Code-loading handshake between a code source (master) and cheat_table (slave).
// A code is transferred on a rising clk edge where code_valid and code_ready are both high.
interface cheat_table_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic [ADDR_W+2*DATA_W:0] code_in;
  logic                     code_valid;
  logic                     code_ready;

  modport master (output code_in, output code_valid, input code_ready);
  modport slave  (input code_in, input code_valid, output code_ready);
endinterface

// File: rtl/cheat_table.sv
// Cheat-code table: serial duplicate-scanning loader plus a combinational
// address/data lookup that overrides bus data with a code's replace value.
module cheat_table #(
  parameter int NUM_CODES = 32,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8,
  localparam int CNT_W    = $clog2(NUM_CODES + 1),
  localparam int IDX_W    = $clog2(NUM_CODES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              clear,
  cheat_table_if.slave      code_if,
  output logic              genie_ovr,
  output logic [DATA_W-1:0] genie_data,
  output logic [CNT_W-1:0]  code_count,
  output logic              load_err,
  output logic [1:0]        o_dbg_state
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SCAN   = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;

  logic [1:0]        r_state;
  logic [IDX_W-1:0]  r_idx;
  logic              r_dup;
  logic [IDX_W-1:0]  r_dup_idx;
  logic [CNT_W-1:0]  r_count;

  logic              r_l_cmp;
  logic [ADDR_W-1:0] r_l_addr;
  logic [DATA_W-1:0] r_l_cmpv;
  logic [DATA_W-1:0] r_l_repl;

  logic              r_occ  [NUM_CODES];
  logic              r_act  [NUM_CODES];
  logic              r_cmp  [NUM_CODES];
  logic [ADDR_W-1:0] r_addr [NUM_CODES];
  logic [DATA_W-1:0] r_cmpv [NUM_CODES];
  logic [DATA_W-1:0] r_repl [NUM_CODES];

  logic              w_accept;
  logic              w_full;
  logic              w_same;
  logic [IDX_W-1:0]  w_wr_idx;
  logic              w_ovr;
  logic [DATA_W-1:0] w_data;

  assign code_if.code_ready = (r_state == IDLE) & ~clear;
  assign w_accept  = code_if.code_valid & code_if.code_ready;
  assign w_full    = (r_count == CNT_W'(NUM_CODES));
  assign w_wr_idx  = r_count[IDX_W-1:0];
  // Address already matches for a duplicate; only the other fields decide toggle vs overwrite.
  assign w_same    = (r_cmp[r_dup_idx] == r_l_cmp) && (r_cmpv[r_dup_idx] == r_l_cmpv) &&
                     (r_repl[r_dup_idx] == r_l_repl);
  assign load_err  = (r_state == COMMIT) & ~r_dup & w_full & ~clear;

  assign code_count  = r_count;
  assign o_dbg_state = r_state;
  assign genie_ovr   = w_ovr;
  assign genie_data  = w_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_dup     <= 1'b0;
      r_dup_idx <= '0;
      r_count   <= '0;
      r_l_cmp   <= 1'b0;
      r_l_addr  <= '0;
      r_l_cmpv  <= '0;
      r_l_repl  <= '0;
      for (int i = 0; i < NUM_CODES; i++) begin
        r_occ[i]  <= 1'b0;
        r_act[i]  <= 1'b0;
        r_cmp[i]  <= 1'b0;
        r_addr[i] <= '0;
        r_cmpv[i] <= '0;
        r_repl[i] <= '0;
      end
    end else if (clear) begin
      // Clear takes priority over any acceptance or commit in the same cycle.
      r_state   <= IDLE;
      r_idx     <= '0;
      r_dup     <= 1'b0;
      r_dup_idx <= '0;
      r_count   <= '0;
      for (int i = 0; i < NUM_CODES; i++) begin
        r_occ[i]  <= 1'b0;
        r_act[i]  <= 1'b0;
        r_cmp[i]  <= 1'b0;
        r_addr[i] <= '0;
        r_cmpv[i] <= '0;
        r_repl[i] <= '0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            {r_l_cmp, r_l_addr, r_l_cmpv, r_l_repl} <= code_if.code_in;
            r_idx   <= '0;
            r_dup   <= 1'b0;
            r_state <= SCAN;
          end
        end
        SCAN: begin
          if (!r_dup && r_occ[r_idx] && (r_addr[r_idx] == r_l_addr)) begin
            r_dup     <= 1'b1;
            r_dup_idx <= r_idx;
          end
          if (r_idx == IDX_W'(NUM_CODES - 1)) r_state <= COMMIT;
          else r_idx <= r_idx + IDX_W'(1);
        end
        COMMIT: begin
          if (r_dup) begin
            if (w_same) begin
              r_act[r_dup_idx] <= ~r_act[r_dup_idx];
            end else begin
              r_act[r_dup_idx]  <= 1'b1;
              r_cmp[r_dup_idx]  <= r_l_cmp;
              r_cmpv[r_dup_idx] <= r_l_cmpv;
              r_repl[r_dup_idx] <= r_l_repl;
            end
          end else if (!w_full) begin
            r_occ[w_wr_idx]  <= 1'b1;
            r_act[w_wr_idx]  <= 1'b1;
            r_cmp[w_wr_idx]  <= r_l_cmp;
            r_addr[w_wr_idx] <= r_l_addr;
            r_cmpv[w_wr_idx] <= r_l_cmpv;
            r_repl[w_wr_idx] <= r_l_repl;
            r_count          <= r_count + CNT_W'(1);
          end
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Walk from the top down so the lowest-index hit is the one left standing.
  always_comb begin
    w_ovr  = 1'b0;
    w_data = '0;
    for (int i = NUM_CODES - 1; i >= 0; i--) begin
      if (enable && r_occ[i] && r_act[i] && (r_addr[i] == addr_in) &&
          (!r_cmp[i] || (r_cmpv[i] == data_in))) begin
        w_ovr  = 1'b1;
        w_data = r_repl[i];
      end
    end
  end

endmodule

// File: tb/tb_cheat_table.sv
// Directed bench for cheat_table: a queue-based table model drives a per-cycle
// lookup/count compare, and literal expectations pin the key scenarios.
module tb_cheat_table;
  localparam int NUM  = 32;
  localparam int AW   = 16;
  localparam int DW   = 8;
  localparam int CW   = 1 + AW + 2 * DW;
  localparam int CNTW = $clog2(NUM + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic          clear = 1'b0;
  logic [AW-1:0] addr_in = '0;
  logic [DW-1:0] data_in = '0;
  logic          genie_ovr;
  logic [DW-1:0] genie_data;
  logic [CNTW-1:0] code_count;
  logic          load_err;
  logic [1:0]    dbg_state;

  cheat_table_if #(.ADDR_W(AW), .DATA_W(DW)) code_if ();

  cheat_table #(.NUM_CODES(NUM), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .addr_in    (addr_in),
    .data_in    (data_in),
    .clear      (clear),
    .code_if    (code_if),
    .genie_ovr  (genie_ovr),
    .genie_data (genie_data),
    .code_count (code_count),
    .load_err   (load_err),
    .o_dbg_state(dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural table model ----------------
  typedef struct {
    logic          cmp_en;
    logic [AW-1:0] addr;
    logic [DW-1:0] cmpv;
    logic [DW-1:0] repl;
    logic          active;
  } slot_t;
  slot_t m_q[$];

  function automatic logic [CW-1:0] mk(input logic c, input logic [AW-1:0] a,
                                       input logic [DW-1:0] v, input logic [DW-1:0] r);
    return {c, a, v, r};
  endfunction

  // Returns 1 when the code must be dropped because the table is full.
  function automatic bit model_load(input logic [CW-1:0] c);
    slot_t s;
    int hit = -1;
    s.cmp_en = c[CW-1];
    s.addr   = c[CW-2 -: AW];
    s.cmpv   = c[2*DW-1 -: DW];
    s.repl   = c[DW-1:0];
    s.active = 1'b1;
    foreach (m_q[i]) if (hit < 0 && m_q[i].addr == s.addr) hit = i;
    if (hit >= 0) begin
      if (m_q[hit].cmp_en == s.cmp_en && m_q[hit].cmpv == s.cmpv && m_q[hit].repl == s.repl)
        m_q[hit].active = ~m_q[hit].active;
      else
        m_q[hit] = s;
      return 1'b0;
    end
    if (m_q.size() < NUM) begin
      m_q.push_back(s);
      return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_lookup(input logic en, input logic [AW-1:0] a, input logic [DW-1:0] d,
                              output logic ovr, output logic [DW-1:0] dat);
    ovr = 1'b0;
    dat = '0;
    if (en) begin
      foreach (m_q[i]) begin
        if (!ovr && m_q[i].active && m_q[i].addr == a && (!m_q[i].cmp_en || m_q[i].cmpv == d)) begin
          ovr = 1'b1;
          dat = m_q[i].repl;
        end
      end
    end
  endtask

  // Per-cycle compare, sampled 1 time unit after the falling edge.
  initial begin
    logic          e_ovr;
    logic [DW-1:0] e_dat;
    forever begin
      @(negedge clk);
      #1;
      if (chk_en) begin
        model_lookup(enable, addr_in, data_in, e_ovr, e_dat);
        check("cyc_genie_ovr", 32'(genie_ovr), 32'(e_ovr));
        check("cyc_genie_data", 32'(genie_data), 32'(e_dat));
        check("cyc_code_count", 32'(code_count), 32'(m_q.size()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  logic [CW-1:0] pend_code;
  int            acc_cyc;
  int            last_err;

  // Called in the low clock phase; returns shortly after the accepting edge.
  task automatic start_load(input logic [CW-1:0] c);
    for (int i = 0; i < NUM + 10 && !code_if.code_ready; i++) @(negedge clk);
    check("ready_before_load", 32'(code_if.code_ready), 32'd1);
    code_if.code_valid = 1'b1;
    code_if.code_in    = c;
    pend_code          = c;
    acc_cyc            = cyc;
    @(posedge clk);
    #1;
    code_if.code_valid = 1'b0;
    code_if.code_in    = ~c;
  endtask

  task automatic finish_load();
    int  low  = 0;
    int  errs = 0;
    bit  done = 1'b0;
    bit  e_err;
    for (int i = 0; i < NUM + 10; i++) begin
      @(negedge clk);
      if (code_if.code_ready) begin
        done = 1'b1;
        break;
      end
      low++;
      errs += int'(load_err);
    end
    check("load_completes", 32'(done), 32'd1);
    e_err = model_load(pend_code);
    last_err = errs;
    check("ready_low_cycles", 32'(low), 32'(NUM + 1));
    check("load_err_pulses", 32'(errs), 32'(e_err));
  endtask

  task automatic load(input logic [CW-1:0] c);
    start_load(c);
    finish_load();
  endtask

  task automatic expect_lookup(input string name, input logic en, input logic [AW-1:0] a,
                               input logic [DW-1:0] d, input logic ovr, input logic [DW-1:0] dat);
    enable  = en;
    addr_in = a;
    data_in = d;
    #1;
    check({name, "_ovr"}, 32'(genie_ovr), 32'(ovr));
    check({name, "_data"}, 32'(genie_data), 32'(dat));
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int a1;
    int errs;
    code_if.code_valid = 1'b0;
    code_if.code_in    = '0;

    reset = 1'b1;
    enable = 1'b1;
    addr_in = 16'h0000;
    #2;
    check("rst_count", 32'(code_count), 32'd0);
    check("rst_ready", 32'(code_if.code_ready), 32'd1);
    check("rst_ovr", 32'(genie_ovr), 32'd0);
    check("rst_data", 32'(genie_data), 32'd0);
    check("rst_load_err", 32'(load_err), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;

    // Single uncompared code
    load(mk(1'b0, 16'h1234, 8'h00, 8'hAB));
    check("count_first", 32'(code_count), 32'd1);
    expect_lookup("hit_1234", 1'b1, 16'h1234, 8'h00, 1'b1, 8'hAB);
    expect_lookup("hit_1234_anydata", 1'b1, 16'h1234, 8'h99, 1'b1, 8'hAB);
    expect_lookup("disabled", 1'b0, 16'h1234, 8'h00, 1'b0, 8'h00);
    expect_lookup("miss_1235", 1'b1, 16'h1235, 8'h00, 1'b0, 8'h00);

    // Compared code and toggle/overwrite behaviour
    load(mk(1'b1, 16'h2000, 8'h55, 8'h66));
    expect_lookup("cmp_hit", 1'b1, 16'h2000, 8'h55, 1'b1, 8'h66);
    expect_lookup("cmp_miss", 1'b1, 16'h2000, 8'h54, 1'b0, 8'h00);
    load(mk(1'b1, 16'h2000, 8'h55, 8'h66));
    expect_lookup("toggled_off", 1'b1, 16'h2000, 8'h55, 1'b0, 8'h00);
    check("count_after_toggle", 32'(code_count), 32'd2);
    load(mk(1'b1, 16'h2000, 8'h55, 8'h66));
    expect_lookup("toggled_on", 1'b1, 16'h2000, 8'h55, 1'b1, 8'h66);
    load(mk(1'b0, 16'h2000, 8'h00, 8'h77));
    expect_lookup("overwrite", 1'b1, 16'h2000, 8'h12, 1'b1, 8'h77);
    check("count_after_overwrite", 32'(code_count), 32'd2);

    // Back-to-back accepts are NUM+2 cycles apart
    load(mk(1'b0, 16'h3000, 8'h00, 8'h30));
    a1 = acc_cyc;
    start_load(mk(1'b0, 16'h3001, 8'h00, 8'h31));
    check("accept_to_accept", 32'(acc_cyc - a1), 32'(NUM + 2));
    finish_load();
    check("count_four", 32'(code_count), 32'd4);

    // Clear during SCAN aborts the load
    start_load(mk(1'b0, 16'h4000, 8'h00, 8'h40));
    repeat (5) @(negedge clk);
    chk_en = 1'b0;
    clear = 1'b1;
    #1;
    check("clear_masks_ready", 32'(code_if.code_ready), 32'd0);
    @(negedge clk);
    clear = 1'b0;
    m_q.delete();
    #1;
    check("clear_count", 32'(code_count), 32'd0);
    check("clear_ready", 32'(code_if.code_ready), 32'd1);
    errs = 0;
    for (int i = 0; i < NUM + 4; i++) begin
      @(negedge clk);
      errs += int'(load_err);
    end
    check("clear_no_err", 32'(errs), 32'd0);
    check("clear_no_commit", 32'(code_count), 32'd0);
    chk_en = 1'b1;
    expect_lookup("clear_miss_1234", 1'b1, 16'h1234, 8'h00, 1'b0, 8'h00);
    expect_lookup("clear_miss_4000", 1'b1, 16'h4000, 8'h00, 1'b0, 8'h00);

    // Fill the table, then overflow
    for (int i = 0; i < NUM; i++) load(mk(1'b0, 16'h5000 + 16'(i), 8'h00, 8'(i + 1)));
    check("count_full", 32'(code_count), 32'(NUM));
    load(mk(1'b0, 16'h6000, 8'h00, 8'hCC));
    check("overflow_err_pulse", 32'(last_err), 32'd1);
    check("overflow_count", 32'(code_count), 32'(NUM));
    expect_lookup("overflow_miss", 1'b1, 16'h6000, 8'h00, 1'b0, 8'h00);
    load(mk(1'b0, 16'h5003, 8'h00, 8'hEE));
    check("reload_full_no_err", 32'(last_err), 32'd0);
    expect_lookup("reload_full_hit", 1'b1, 16'h5003, 8'h00, 1'b1, 8'hEE);
    expect_lookup("slot_last", 1'b1, 16'h501F, 8'h00, 1'b1, 8'h20);

    // Async reset in the middle of COMMIT
    start_load(mk(1'b0, 16'h5004, 8'h00, 8'h99));
    for (int i = 0; i < NUM + 5; i++) begin
      @(negedge clk);
      if (dbg_state == 2'd2) break;
    end
    check("reached_commit", 32'(dbg_state), 32'd2);
    chk_en = 1'b0;
    #1;
    reset = 1'b1;
    enable = 1'b1;
    addr_in = 16'h5000;
    #1;
    check("arst_count", 32'(code_count), 32'd0);
    check("arst_ovr", 32'(genie_ovr), 32'd0);
    check("arst_load_err", 32'(load_err), 32'd0);
    check("arst_ready", 32'(code_if.code_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    m_q.delete();
    #1;
    check("arst_ready_after", 32'(code_if.code_ready), 32'd1);
    chk_en = 1'b1;
    expect_lookup("arst_miss_5004", 1'b1, 16'h5004, 8'h00, 1'b0, 8'h00);

    // Same address reloaded with an uncompared variant lands in the same slot
    load(mk(1'b1, 16'h7000, 8'h10, 8'h01));
    load(mk(1'b0, 16'h7000, 8'h00, 8'h02));
    expect_lookup("variant_hit", 1'b1, 16'h7000, 8'h33, 1'b1, 8'h02);
    check("variant_count", 32'(code_count), 32'd1);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
